npu_layer_seq: RTL and testbench
================================

// Module: npu_layer_seq
// PURPOSE
//  Parametrised layer sequencer for the NPU datapath: input buffer -> MAC -> ReLU -> PISO -> memory write.
//  Runs CFG_NEURONS neurons of CFG_LEN inputs each from one START, then pulses DONE.
//  Overlaps output drain of neuron n with accumulation of neuron n+1.
//  Output drain is N_OUT beats with optional write backpressure.
// PARAMETERS
//  CNT_W  16  width of inputs-per-neuron count CFG_LEN
//  NRN_W  8   width of neuron count CFG_NEURONS / NEURON_IDX
//  N_OUT  4   PISO beats (WR_EN cycles) per neuron result, >=1
// PORTS
//  CLKEXT       in   1      single clock, all state on rising edge
//  RST_N        in   1      asynchronous, active-low reset
//  START        in   1      start layer; sampled only in IDLE
//  CFG_LEN      in   CNT_W  inputs per neuron; latched at START; 0 treated as 1
//  CFG_NEURONS  in   NRN_W  neurons in layer; latched at START; 0 treated as 1
//  WR_READY     in   1      memory accepts write beat (backpressure, see CONFIGURATION)
//  EN_BUF_IN / CLR_BUF_IN          out 1  input buffer enable / clear
//  EN_MAC / RST_MAC                out 1  MAC enable / bias load (clear)
//  EN_RELU                         out 1  ReLU capture of finished MAC result
//  SHIFT_OUT / EN_PISO_OUT / CLR_PISO_OUT  out 1  PISO shift(1)/load(0), enable, clear
//  WR_EN                           out 1  output write beat valid
//  BUSY         out  1      high in every accumulate-FSM state except IDLE
//  DONE         out  1      one-cycle pulse, layer complete
//  NEURON_IDX   out  NRN_W  index of neuron being accumulated
// BEHAVIOUR
//  Two FSMs, state registers async-cleared by RST_N. Outputs are Moore decodes of state, except DONE (registered).
//  Accumulate FSM: IDLE, BIAS, ACC, HOLD, LAST, WAIT.
//   IDLE: CLR_BUF_IN=1, RST_MAC=1, CLR_PISO_OUT=1, others 0. START -> BIAS; latch cfg, NEURON_IDX=0.
//   BIAS (1 cyc): EN_MAC=1, RST_MAC=1, CLR_BUF_IN=1; EN_RELU=1 if NEURON_IDX!=0.
//     Load down-counter with CFG_LEN-1; -> ACC.
//   ACC: EN_BUF_IN=1, EN_MAC=1. Counter decrements each cycle. At cnt==0 (CFG_LEN cycles):
//     last neuron                  -> LAST
//     else out FSM in O_IDLE       -> BIAS, NEURON_IDX+1
//     else                         -> HOLD
//   HOLD: all enables 0. Out FSM in O_IDLE -> BIAS, NEURON_IDX+1.
//   LAST (1 cyc): EN_MAC=1, EN_RELU=1 -> WAIT.
//   WAIT: all 0. OUT_DONE -> IDLE with DONE=1 for that first IDLE cycle.
//  Output FSM: O_IDLE, O_LOAD, O_SHIFT, O_DONE.
//   EN_RELU=1 in O_IDLE -> O_LOAD; EN_RELU at any other time is a design error (assert).
//   O_LOAD (1 cyc): EN_PISO_OUT=1, SHIFT_OUT=0.
//   O_SHIFT: EN_PISO_OUT=1, SHIFT_OUT=1, WR_EN=1.
//     A beat completes when WR_EN && WR_READY; beat counter 0..N_OUT-1.
//     After the N_OUT-th completed beat -> O_DONE.
//   O_DONE (1 cyc): internal OUT_DONE=1 -> O_IDLE.
//  Latency, one neuron (L=CFG_LEN, no stalls): START seen cycle 0; ACC cycles 2..L+1; LAST L+2;
//   WR_EN cycles L+4..L+3+N_OUT; DONE cycle L+5+N_OUT.
//  START while BUSY is ignored; cfg inputs may change freely after latching.
//  RST_N low at any time: both FSMs to idle, counters 0, outputs to IDLE/O_IDLE values, DONE=0.
// CONFIGURATION
//  NPU_SEQ_BACKPRESSURE_EN defined: O_SHIFT holds (WR_EN stays 1, PISO not shifted, EN_PISO_OUT=0)
//   while WR_READY=0; the accumulate FSM may then wait in HOLD/WAIT.
//  Undefined: WR_READY ignored (treated as 1); O_SHIFT is exactly N_OUT cycles.
// STRUCTURE
//  Shared package npu_seq_pkg: state encodings for both FSMs and the default widths.
//  Sub-module npu_out_seq: output FSM plus beat counter. EN_RELU in; OUT_DONE, PISO/WR signals out.
//  Top instantiates it next to the accumulate FSM and the two counters.
// TESTING
//  1. L=4, neurons=1, N_OUT=4, WR_READY=1: WR_EN high cycles 8-11; DONE pulse at cycle 13 only.
//  2. L=8, neurons=3: EN_RELU pulses 3 times; NEURON_IDX 0,1,2; 12 WR_EN beats; no HOLD entered.
//  3. L=1, neurons=2, N_OUT=4: HOLD entered until O_IDLE; EN_RELU never while out FSM busy.
//  4. CFG_LEN=0, CFG_NEURONS=0: behaves as L=1, 1 neuron; DONE at cycle 10 (N_OUT=4).
//  5. BACKPRESSURE_EN, WR_READY=0 for 3 cycles mid-shift: exactly N_OUT accepted beats; DONE delayed 3 cycles.
//  6. RST_N low during ACC of neuron 1: immediate IDLE outputs; new START runs a clean layer; START while BUSY ignored.

Source files
------------

// File: rtl/npu_seq_pkg.sv
// Shared definitions for the NPU layer sequencer.
// Holds the default widths, both FSM state encodings, the accumulate-side
// control bundle and its state decode.
package npu_seq_pkg;

    localparam int unsigned CNT_W_DEF = 16;
    localparam int unsigned NRN_W_DEF = 8;
    localparam int unsigned N_OUT_DEF = 4;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_BIAS = 3'd1,
        S_ACC  = 3'd2,
        S_HOLD = 3'd3,
        S_LAST = 3'd4,
        S_WAIT = 3'd5
    } acc_state_t;

    typedef enum logic [1:0] {
        O_IDLE  = 2'd0,
        O_LOAD  = 2'd1,
        O_SHIFT = 2'd2,
        O_DONE  = 2'd3
    } out_state_t;

    typedef struct packed {
        logic en_buf_in;
        logic clr_buf_in;
        logic en_mac;
        logic rst_mac;
        logic en_relu;
        logic clr_piso_out;
    } acc_ctl_t;

    // Moore decode of the accumulate FSM; not_first enables ReLU capture in BIAS.
    function automatic acc_ctl_t acc_decode(input acc_state_t s, input logic not_first);
        acc_ctl_t c;
        c = '0;
        case (s)
            S_IDLE: begin
                c.clr_buf_in   = 1'b1;
                c.rst_mac      = 1'b1;
                c.clr_piso_out = 1'b1;
            end
            S_BIAS: begin
                c.en_mac     = 1'b1;
                c.rst_mac    = 1'b1;
                c.clr_buf_in = 1'b1;
                c.en_relu    = not_first;
            end
            S_ACC: begin
                c.en_buf_in = 1'b1;
                c.en_mac    = 1'b1;
            end
            S_LAST: begin
                c.en_mac  = 1'b1;
                c.en_relu = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/npu_layer_seq_out.sv
// npu_out_seq: output drain FSM (ReLU capture -> PISO load -> N_OUT write beats).
// Ports: i_clk, i_rst_n (async active-low), i_en_relu (start drain),
//        i_wr_ready (beat accept), o_out_done / o_out_idle (status to the
//        accumulate FSM), o_shift_out, o_en_piso_out, o_wr_en.
// Macro NPU_SEQ_BACKPRESSURE_EN: when defined, WR_READY=0 stalls O_SHIFT;
// otherwise WR_READY is ignored and O_SHIFT lasts exactly N_OUT cycles.
module npu_out_seq
    import npu_seq_pkg::*;
#(
    parameter int unsigned N_OUT = N_OUT_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en_relu,
    input  logic i_wr_ready,
    output logic o_out_done,
    output logic o_out_idle,
    output logic o_shift_out,
    output logic o_en_piso_out,
    output logic o_wr_en
);

    localparam int unsigned BEAT_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(N_OUT - 1);

    out_state_t        r_state, w_state_nxt;
    logic [BEAT_W-1:0] r_beat, w_beat_nxt;
    logic              r_shift_wr, w_shift_wr_nxt;
    logic              r_en_piso, w_en_piso_nxt;
    logic              w_ready;
    logic              w_beat_done;

`ifdef NPU_SEQ_BACKPRESSURE_EN
    assign w_ready = i_wr_ready;
`else
    logic w_unused_wr_ready;
    assign w_unused_wr_ready = i_wr_ready;
    assign w_ready = 1'b1;
`endif

    assign w_beat_done = (r_state == O_SHIFT) && w_ready;

    // Next state, beat counter and next-cycle output decode.
    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat;
        case (r_state)
            O_IDLE:  if (i_en_relu) w_state_nxt = O_LOAD;
            O_LOAD:  w_state_nxt = O_SHIFT;
            O_SHIFT: begin
                if (w_beat_done) begin
                    if (r_beat == BEAT_LAST) begin
                        w_state_nxt = O_DONE;
                        w_beat_nxt  = '0;
                    end else begin
                        w_beat_nxt = r_beat + BEAT_W'(1);
                    end
                end
            end
            O_DONE:  w_state_nxt = O_IDLE;
            default: w_state_nxt = O_IDLE;
        endcase
        w_shift_wr_nxt = (w_state_nxt == O_SHIFT);
        w_en_piso_nxt  = (w_state_nxt == O_LOAD) || (w_state_nxt == O_SHIFT);
    end

    // State, counter and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= O_IDLE;
            r_beat     <= '0;
            r_shift_wr <= 1'b0;
            r_en_piso  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_beat     <= w_beat_nxt;
            r_shift_wr <= w_shift_wr_nxt;
            r_en_piso  <= w_en_piso_nxt;
        end
    end

    assign o_out_done    = (r_state == O_DONE);
    assign o_out_idle    = (r_state == O_IDLE);
    assign o_shift_out   = r_shift_wr;
    assign o_wr_en       = r_shift_wr;
    // A stalled beat keeps the PISO word in place.
    assign o_en_piso_out = r_en_piso && (!r_shift_wr || w_ready);

    // A new result may only be captured once the previous one has drained.
    a_relu_when_idle: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        i_en_relu |-> (r_state == O_IDLE));

endmodule

// File: rtl/npu_layer_seq.sv
// npu_layer_seq: layer sequencer for buffer -> MAC -> ReLU -> PISO -> write.
// Runs CFG_NEURONS neurons of CFG_LEN inputs per START, overlapping the
// output drain of one neuron with accumulation of the next, then pulses DONE.
// Ports: CLKEXT, RST_N (async active-low), START, CFG_LEN, CFG_NEURONS,
//        WR_READY in; datapath enables/clears, WR_EN, BUSY, DONE, NEURON_IDX out.
// Macro NPU_SEQ_BACKPRESSURE_EN enables WR_READY backpressure in npu_out_seq.
module npu_layer_seq
    import npu_seq_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned NRN_W = NRN_W_DEF,
    parameter int unsigned N_OUT = N_OUT_DEF
) (
    input  logic             CLKEXT,
    input  logic             RST_N,
    input  logic             START,
    input  logic [CNT_W-1:0] CFG_LEN,
    input  logic [NRN_W-1:0] CFG_NEURONS,
    input  logic             WR_READY,
    output logic             EN_BUF_IN,
    output logic             CLR_BUF_IN,
    output logic             EN_MAC,
    output logic             RST_MAC,
    output logic             EN_RELU,
    output logic             SHIFT_OUT,
    output logic             EN_PISO_OUT,
    output logic             CLR_PISO_OUT,
    output logic             WR_EN,
    output logic             BUSY,
    output logic             DONE,
    output logic [NRN_W-1:0] NEURON_IDX
);

    acc_state_t       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [CNT_W-1:0] r_len_m1, w_len_m1_nxt;
    logic [NRN_W-1:0] r_idx, w_idx_nxt;
    logic [NRN_W-1:0] r_last_idx, w_last_idx_nxt;
    acc_ctl_t         r_ctl, w_ctl_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;
    logic             w_last;
    logic             w_out_idle;
    logic             w_out_done;

    assign w_last = (r_idx == r_last_idx);

    // Accumulate FSM: next state, counters and next-cycle output decode.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_len_m1_nxt   = r_len_m1;
        w_idx_nxt      = r_idx;
        w_last_idx_nxt = r_last_idx;
        w_done_nxt     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (START) begin
                    w_state_nxt    = S_BIAS;
                    w_idx_nxt      = '0;
                    w_len_m1_nxt   = (CFG_LEN == '0) ? '0 : CFG_LEN - CNT_W'(1);
                    w_last_idx_nxt = (CFG_NEURONS == '0) ? '0 : CFG_NEURONS - NRN_W'(1);
                end
            end
            S_BIAS: begin
                w_state_nxt = S_ACC;
                w_cnt_nxt   = r_len_m1;
            end
            S_ACC: begin
                if (r_cnt == '0) begin
                    // Hold off any ReLU capture (BIAS or LAST) until the drain is idle.
                    if (!w_out_idle) begin
                        w_state_nxt = S_HOLD;
                    end else if (w_last) begin
                        w_state_nxt = S_LAST;
                    end else begin
                        w_state_nxt = S_BIAS;
                        w_idx_nxt   = r_idx + NRN_W'(1);
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            S_HOLD: begin
                if (w_out_idle) begin
                    if (w_last) begin
                        w_state_nxt = S_LAST;
                    end else begin
                        w_state_nxt = S_BIAS;
                        w_idx_nxt   = r_idx + NRN_W'(1);
                    end
                end
            end
            S_LAST: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (w_out_done) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        w_ctl_nxt  = acc_decode(w_state_nxt, w_idx_nxt != '0);
        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    // Accumulate FSM state, counters and registered outputs.
    always_ff @(posedge CLKEXT or negedge RST_N) begin
        if (!RST_N) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_len_m1   <= '0;
            r_idx      <= '0;
            r_last_idx <= '0;
            r_ctl      <= acc_decode(S_IDLE, 1'b0);
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_len_m1   <= w_len_m1_nxt;
            r_idx      <= w_idx_nxt;
            r_last_idx <= w_last_idx_nxt;
            r_ctl      <= w_ctl_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    npu_out_seq #(
        .N_OUT (N_OUT)
    ) u_out_seq (
        .i_clk         (CLKEXT),
        .i_rst_n       (RST_N),
        .i_en_relu     (r_ctl.en_relu),
        .i_wr_ready    (WR_READY),
        .o_out_done    (w_out_done),
        .o_out_idle    (w_out_idle),
        .o_shift_out   (SHIFT_OUT),
        .o_en_piso_out (EN_PISO_OUT),
        .o_wr_en       (WR_EN)
    );

    assign EN_BUF_IN    = r_ctl.en_buf_in;
    assign CLR_BUF_IN   = r_ctl.clr_buf_in;
    assign EN_MAC       = r_ctl.en_mac;
    assign RST_MAC      = r_ctl.rst_mac;
    assign EN_RELU      = r_ctl.en_relu;
    assign CLR_PISO_OUT = r_ctl.clr_piso_out;
    assign BUSY         = r_busy;
    assign DONE         = r_done;
    assign NEURON_IDX   = r_idx;

endmodule

// File: tb/tb_npu_layer_seq.sv
// Self-checking bench for npu_layer_seq (N_OUT=4).
// Table of layer configurations with hand-derived timing, plus sequences for
// write stalls, START while busy and reset during accumulation.
module tb_npu_layer_seq;

    localparam int unsigned CNT_W = 16;
    localparam int unsigned NRN_W = 8;
    localparam int unsigned N_OUT = 4;
`ifdef NPU_SEQ_BACKPRESSURE_EN
    localparam bit BP = 1'b1;
`else
    localparam bit BP = 1'b0;
`endif
    localparam int IDLE_WORD = 11'b0101_0001_000;

    logic             CLKEXT = 1'b0;
    logic             RST_N;
    logic             START;
    logic [CNT_W-1:0] CFG_LEN;
    logic [NRN_W-1:0] CFG_NEURONS;
    logic             WR_READY;
    logic EN_BUF_IN, CLR_BUF_IN, EN_MAC, RST_MAC, EN_RELU;
    logic SHIFT_OUT, EN_PISO_OUT, CLR_PISO_OUT, WR_EN, BUSY, DONE;
    logic [NRN_W-1:0] NEURON_IDX;

    always #5 CLKEXT = ~CLKEXT;

    npu_layer_seq #(.CNT_W(CNT_W), .NRN_W(NRN_W), .N_OUT(N_OUT)) dut (
        .CLKEXT(CLKEXT), .RST_N(RST_N), .START(START), .CFG_LEN(CFG_LEN),
        .CFG_NEURONS(CFG_NEURONS), .WR_READY(WR_READY), .EN_BUF_IN(EN_BUF_IN),
        .CLR_BUF_IN(CLR_BUF_IN), .EN_MAC(EN_MAC), .RST_MAC(RST_MAC), .EN_RELU(EN_RELU),
        .SHIFT_OUT(SHIFT_OUT), .EN_PISO_OUT(EN_PISO_OUT), .CLR_PISO_OUT(CLR_PISO_OUT),
        .WR_EN(WR_EN), .BUSY(BUSY), .DONE(DONE), .NEURON_IDX(NEURON_IDX)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int out_word();
        return int'({EN_BUF_IN, CLR_BUF_IN, EN_MAC, RST_MAC, EN_RELU, SHIFT_OUT,
                     EN_PISO_OUT, CLR_PISO_OUT, WR_EN, BUSY, DONE});
    endfunction

    // Scoreboard queues: NEURON_IDX expected at each EN_RELU, DONE cycle per layer.
    int q_relu[$];
    int q_done[$];

    // Monitor state, cycle 0 is the cycle in which START is accepted.
    bit mon_on;
    int cyc, wr_cycles, acc_beats, relu_cnt, quiet, first_wr, done_cnt;

    always @(negedge CLKEXT) begin
        if (RST_N) begin
            if (!mon_on && START && !BUSY) begin
                mon_on = 1'b1;
                cyc    = 0;
            end else if (mon_on) begin
                cyc++;
            end
            if (mon_on) begin
                if (WR_EN) begin
                    wr_cycles++;
                    if (first_wr < 0) first_wr = cyc;
                    if (!BP || WR_READY) acc_beats++;
                    check("shift_during_wr", int'(SHIFT_OUT), 1);
                    check("piso_en_during_wr", int'(EN_PISO_OUT), int'(!BP || WR_READY));
                end
                if (EN_RELU) begin
                    relu_cnt++;
                    if (q_relu.size() == 0) check("relu_unexpected", int'(NEURON_IDX), -1);
                    else check("relu_idx", int'(NEURON_IDX), q_relu.pop_front());
                end
                if (BUSY && !EN_BUF_IN && !EN_MAC && !EN_RELU) quiet++;
                if (DONE) begin
                    done_cnt++;
                    if (q_done.size() == 0) check("done_unexpected", cyc, -1);
                    else check("done_cycle", cyc, q_done.pop_front());
                end
            end
        end
    end

    task automatic mon_clear();
        mon_on = 1'b0; cyc = 0; wr_cycles = 0; acc_beats = 0;
        relu_cnt = 0; quiet = 0; first_wr = -1; done_cnt = 0;
    endtask

    // One layer: stall_at/busy_start_at are cycle numbers (0 = not used).
    task automatic run_layer(input int len, input int nrn, input int done_c,
                             input int stall_at, input int busy_start_at);
        int nrn_eff;
        int c;
        nrn_eff = (nrn == 0) ? 1 : nrn;
        mon_clear();
        for (int k = 1; k < nrn_eff; k++) q_relu.push_back(k);
        q_relu.push_back(nrn_eff - 1);
        q_done.push_back(done_c);
        @(posedge CLKEXT); #1;
        START = 1'b1; CFG_LEN = CNT_W'(len); CFG_NEURONS = NRN_W'(nrn);
        @(posedge CLKEXT); #1;
        START = 1'b0; CFG_LEN = CNT_W'($urandom); CFG_NEURONS = NRN_W'($urandom);
        c = 1;
        while (done_cnt == 0 && c < 400) begin
            if (c == stall_at) WR_READY = 1'b0;
            if (c == stall_at + 3) WR_READY = 1'b1;
            START = (c == busy_start_at);
            if (START) begin
                CFG_LEN = CNT_W'(20); CFG_NEURONS = NRN_W'(5);
            end
            @(posedge CLKEXT); #1;
            c++;
        end
        START = 1'b0; WR_READY = 1'b1;
        check("done_seen", done_cnt, 1);
        repeat (4) @(posedge CLKEXT);
        #1;
        check("done_single_pulse", done_cnt, 1);
        check("idle_after_done", out_word(), IDLE_WORD);
    endtask

    typedef struct {
        int len; int nrn; int done_c; int beats; int relu; int quiet; int first_wr;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{len: 4, nrn: 1, done_c: 13, beats: 4,  relu: 1, quiet: 6,  first_wr: 8};
        vecs[1] = '{len: 8, nrn: 3, done_c: 35, beats: 12, relu: 3, quiet: 6,  first_wr: 12};
        vecs[2] = '{len: 1, nrn: 2, done_c: 18, beats: 8,  relu: 2, quiet: 12, first_wr: 5};
        vecs[3] = '{len: 0, nrn: 0, done_c: 10, beats: 4,  relu: 1, quiet: 6,  first_wr: 5};
        vecs[4] = '{len: 3, nrn: 2, done_c: 20, beats: 8,  relu: 2, quiet: 10, first_wr: 7};
        vecs[5] = '{len: 6, nrn: 2, done_c: 23, beats: 8,  relu: 2, quiet: 7,  first_wr: 10};
        vecs[6] = '{len: 7, nrn: 2, done_c: 24, beats: 8,  relu: 2, quiet: 6,  first_wr: 11};

        mon_clear();
        RST_N = 1'b0; START = 1'b0; CFG_LEN = '0; CFG_NEURONS = '0; WR_READY = 1'b1;
        #12;
        check("reset_outputs", out_word(), IDLE_WORD);
        check("reset_idx", int'(NEURON_IDX), 0);
        @(negedge CLKEXT); RST_N = 1'b1;
        repeat (2) @(posedge CLKEXT);
        #1;
        check("idle_no_start", out_word(), IDLE_WORD);

        for (int i = 0; i < 7; i++) begin
            run_layer(vecs[i].len, vecs[i].nrn, vecs[i].done_c, 0, 0);
            check($sformatf("v%0d_beats", i), acc_beats, vecs[i].beats);
            check($sformatf("v%0d_wr_cycles", i), wr_cycles, vecs[i].beats);
            check($sformatf("v%0d_relu", i), relu_cnt, vecs[i].relu);
            check($sformatf("v%0d_quiet", i), quiet, vecs[i].quiet);
            check($sformatf("v%0d_first_wr", i), first_wr, vecs[i].first_wr);
        end

        // Write stall for cycles 9..11 in the middle of the shift phase.
        run_layer(4, 1, BP ? 16 : 13, 9, 0);
        check("stall_beats", acc_beats, 4);
        check("stall_wr_cycles", wr_cycles, BP ? 7 : 4);

        // START pulsed during ACC with different cfg must be ignored.
        run_layer(4, 1, 13, 0, 3);
        check("busy_start_beats", acc_beats, 4);
        check("busy_start_relu", relu_cnt, 1);

        // Reset during ACC of neuron 1 of a 3-neuron layer.
        mon_clear();
        q_relu.push_back(1);
        @(posedge CLKEXT); #1;
        START = 1'b1; CFG_LEN = CNT_W'(8); CFG_NEURONS = NRN_W'(3);
        @(posedge CLKEXT); #1;
        START = 1'b0;
        begin
            int n;
            n = 0;
            while (!(NEURON_IDX == NRN_W'(1) && EN_BUF_IN) && n < 100) begin
                @(negedge CLKEXT);
                n++;
            end
            check("reach_acc_n1", int'(n < 100), 1);
        end
        #2 RST_N = 1'b0;
        #1;
        check("midrun_reset_outputs", out_word(), IDLE_WORD);
        check("midrun_reset_idx", int'(NEURON_IDX), 0);
        q_relu.delete();
        q_done.delete();
        mon_clear();
        @(negedge CLKEXT);
        check("reset_held_outputs", out_word(), IDLE_WORD);
        RST_N = 1'b1;
        run_layer(4, 1, 13, 0, 0);
        check("post_reset_beats", acc_beats, 4);
        check("post_reset_first_wr", first_wr, 8);

        check("relu_queue_empty", q_relu.size(), 0);
        check("done_queue_empty", q_done.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
